// File: rtl/mem_bist_ctrl_pkg.sv
// Shared definitions for the memory BIST controller: state encoding,
// default background pattern and the run-length helper used by benches.
package mem_bist_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_W_BG   = 4'd1,
    S_UP_RD  = 4'd2,
    S_UP_WR  = 4'd3,
    S_DN_RD  = 4'd4,
    S_DN_WR  = 4'd5,
    S_FR_RD  = 4'd6,
    S_FR_CMP = 4'd7,
    S_DONE   = 4'd8
  } bist_state_t;

  localparam logic [7:0] BG_DEFAULT  = 8'h55;
  localparam int         DEPTH_DEF   = 16;

  // Busy cycles of a clean run: one write pass plus three read/act passes of two cycles each.
  function automatic int run_len(input int depth);
    return 7 * depth;
  endfunction

  localparam int RUN_LEN_DEF = 7 * DEPTH_DEF;

endpackage

// File: rtl/mem_bist_addr_cnt.sv
// Loadable up/down address counter; is_last flags the terminal address
// for the current sweep direction so phases never rely on wrap-around.
module mem_bist_addr_cnt #(
  parameter int ADDR_BITS = 4,
  parameter int RAM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_zero,
  input  logic                 load_max,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 down,
  output logic [ADDR_BITS-1:0] cnt,
  output logic                 is_last
);

  localparam logic [ADDR_BITS-1:0] MAX = ADDR_BITS'(RAM_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (load_zero) cnt <= '0;
    else if (load_max)  cnt <= MAX;
    else if (inc)       cnt <= cnt + 1'b1;
    else if (dec)       cnt <= cnt - 1'b1;
  end

  assign is_last = down ? (cnt == '0) : (cnt == MAX);

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style BIST initiator for a small synchronous RAM: W(BG), up R(BG)W(~BG),
// down R(~BG)W(BG), final up R(BG); aborts on the first miscompare.
module mem_bist_ctrl
  import mem_bist_ctrl_pkg::*;
#(
  parameter int                   ADDR_BITS = 4,
  parameter int                   DATA_BITS = 8,
  parameter int                   RAM_DEPTH = 16,
  parameter logic [DATA_BITS-1:0] BG        = DATA_BITS'(BG_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [DATA_BITS-1:0] fail_data
);

  bist_state_t          state_q, state_d;
  logic                 ld_zero, ld_max, inc, dec, down, mismatch, is_last;
  logic [ADDR_BITS-1:0] cnt;

  mem_bist_addr_cnt #(.ADDR_BITS(ADDR_BITS), .RAM_DEPTH(RAM_DEPTH)) u_cnt (
    .clk(clk), .rst(rst), .load_zero(ld_zero), .load_max(ld_max),
    .inc(inc), .dec(dec), .down(down), .cnt(cnt), .is_last(is_last)
  );

  assign down = (state_q == S_DN_RD) || (state_q == S_DN_WR);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_zero  = 1'b0;
    ld_max   = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_W_BG;
        ld_zero = 1'b1;
      end
      S_W_BG: begin
        if (is_last) begin state_d = S_UP_RD; ld_zero = 1'b1; end
        else inc = 1'b1;
      end
      S_UP_RD: state_d = S_UP_WR;
      S_UP_WR: begin
        mismatch = (mem_rdata != BG);
        if (mismatch)     state_d = S_DONE;
        else if (is_last) begin state_d = S_DN_RD; ld_max = 1'b1; end
        else              begin state_d = S_UP_RD; inc = 1'b1; end
      end
      S_DN_RD: state_d = S_DN_WR;
      S_DN_WR: begin
        mismatch = (mem_rdata != ~BG);
        if (mismatch)     state_d = S_DONE;
        else if (is_last) begin state_d = S_FR_RD; ld_zero = 1'b1; end
        else              begin state_d = S_DN_RD; dec = 1'b1; end
      end
      S_FR_RD: state_d = S_FR_CMP;
      S_FR_CMP: begin
        mismatch = (mem_rdata != BG);
        if (mismatch || is_last) state_d = S_DONE;
        else begin state_d = S_FR_RD; inc = 1'b1; end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM strobes are pure state decodes; address is gated so idle drives zero.
  always_comb begin
    mem_wr_en = (state_q == S_W_BG) || (state_q == S_UP_WR) || (state_q == S_DN_WR);
    mem_rd_en = (state_q == S_UP_RD) || (state_q == S_DN_RD) || (state_q == S_FR_RD);
    mem_addr  = (mem_wr_en || mem_rd_en) ? cnt : '0;
    case (state_q)
      S_W_BG, S_DN_WR: mem_wdata = BG;
      S_UP_WR:         mem_wdata = ~BG;
      default:         mem_wdata = '0;
    endcase
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end
      if (mismatch) begin
        fail_addr <= cnt;
        fail_data <= mem_rdata;
      end
      if (state_q == S_FR_CMP && !mismatch && is_last) pass <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a 1-cycle-latency RAM model and injectable faults.
module tb_mem_bist_ctrl;
  import mem_bist_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mem_addr, fail_addr;
  logic       mem_wr_en, mem_rd_en, busy, done, pass;
  logic [7:0] mem_wdata, mem_rdata, fail_data;

  int total = 0;
  int bad = 0;

  bit fault_stuck = 1'b0;
  bit fault_alias = 1'b0;
  logic [7:0] ram [16];

  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, busy_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  // RAM model: registered read, holds rdata on non-read cycles
  always @(posedge clk) begin
    if (mem_wr_en && !mem_rd_en) begin
      ram[mem_addr] <= (fault_stuck && mem_addr == 4'd5) ? (mem_wdata | 8'h01) : mem_wdata;
      if (fault_alias && mem_addr == 4'd3) ram[11] <= mem_wdata;
    end
    if (mem_rd_en && !mem_wr_en) mem_rdata <= ram[mem_addr];
  end

  initial mem_rdata = 8'h00;

  always @(negedge clk) begin
    if (mem_wr_en) wr_cnt++;
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en && mem_rd_en) both_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy, done, pass, fail_addr, fail_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h wr=%b rd=%b wd=%h busy=%b done=%b pass=%b fa=%h fd=%h want all 0",
               mem_addr, mem_wr_en, mem_rd_en, mem_wdata, busy, done, pass, fail_addr, fail_data);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || pass !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: busy=%b pass=%b want 0 0", busy, pass);
    end
  endtask

  task automatic test_clean();
    int b0, w0, r0, d0, x0;
    bit ok;
    fault_stuck = 1'b0; fault_alias = 1'b0;
    b0 = busy_cnt; w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; x0 = both_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== 8'h55 || busy !== 1'b1) begin
      bad++; $display("FAIL first_write: wr=%b addr=%h wd=%h busy=%b want 1 0 55 1",
                      mem_wr_en, mem_addr, mem_wdata, busy);
    end
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL clean_done_timeout: no done within 400 cycles"); end
    total++;
    if (busy_cnt - b0 !== 112) begin
      bad++; $display("FAIL clean_busy_len: got %0d want 112", busy_cnt - b0);
    end
    total++;
    if (pass !== 1'b1) begin bad++; $display("FAIL clean_pass: got %b want 1", pass); end
    total++;
    if (wr_cnt - w0 !== 48 || rd_cnt - r0 !== 48) begin
      bad++; $display("FAIL clean_access_counts: wr=%0d rd=%0d want 48 48", wr_cnt - w0, rd_cnt - r0);
    end
    total++;
    if (both_cnt - x0 !== 0) begin
      bad++; $display("FAIL wr_rd_overlap: got %0d want 0", both_cnt - x0);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width: done=%b pulses=%0d busy=%b want 0 1 0", done, done_cnt - d0, busy);
    end
  endtask

  task automatic test_stuck_at();
    bit ok;
    int d0;
    fault_stuck = 1'b1; fault_alias = 1'b0;
    d0 = done_cnt;
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stuck_done_timeout: no done within 400 cycles"); end
    total++;
    if (fail_addr !== 4'd5 || fail_data !== 8'hAB || pass !== 1'b0) begin
      bad++; $display("FAIL stuck_result: fa=%h fd=%h pass=%b want 5 ab 0", fail_addr, fail_data, pass);
    end
    @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL stuck_done_count: got %0d want 1", done_cnt - d0); end
    fault_stuck = 1'b0;
  endtask

  task automatic test_alias();
    bit ok;
    fault_alias = 1'b1;
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL alias_done_timeout: no done within 400 cycles"); end
    total++;
    if (fail_addr !== 4'd11 || fail_data !== 8'hAA || pass !== 1'b0) begin
      bad++; $display("FAIL alias_result: fa=%h fd=%h pass=%b want b aa 0", fail_addr, fail_data, pass);
    end
    @(negedge clk);
    fault_alias = 1'b0;
  endtask

  task automatic test_back_to_back();
    int b0;
    bit ok;
    b0 = busy_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++;
    if (pass !== 1'b0 || fail_addr !== 4'd0 || fail_data !== 8'h00) begin
      bad++; $display("FAIL start_clears: pass=%b fa=%h fd=%h want 0 0 00", pass, fail_addr, fail_data);
    end
    for (int c = 2; c <= 50; c++) begin
      start = (c == 10 || c == 50);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(ok);
    total++;
    if (!ok || busy_cnt - b0 !== RUN_LEN_DEF) begin
      bad++; $display("FAIL restart_ignored_len: ok=%b busy=%0d want 1 112", ok, busy_cnt - b0);
    end
    @(negedge clk);
    b0 = busy_cnt;
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok || busy_cnt - b0 !== 112 || pass !== 1'b1 || fail_addr !== 4'd0 || fail_data !== 8'h00) begin
      bad++; $display("FAIL second_run: ok=%b busy=%0d pass=%b fa=%h fd=%h want 1 112 1 0 00",
                      ok, busy_cnt - b0, pass, fail_addr, fail_data);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int d0, b0;
    bit ok;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (39) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 8'h00) begin
      bad++; $display("FAIL mid_reset_outputs: busy=%b wr=%b rd=%b addr=%h wd=%h want all 0",
                      busy, mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_no_done: pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
    b0 = busy_cnt;
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok || busy_cnt - b0 !== 112 || pass !== 1'b1) begin
      bad++; $display("FAIL after_reset_run: ok=%b busy=%0d pass=%b want 1 112 1", ok, busy_cnt - b0, pass);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_at();
    test_alias();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
